controle_varredura_pwm: RTL

//  Sequencer that drives the 2-bit width code of the PWM generator (largura

---
 rtl/controle_varredura_pwm.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/controle_varredura_pwm.sv
`default_nettype none
// ============================================================================
// Module  : controle_varredura_pwm
// Brief   : Triangular sweep sequencer for the PWM width code, with manual
//           pre-emption and dwells aligned to whole PWM periods.
// Revision: 1.0
// ============================================================================
module controle_varredura_pwm #(
    parameter int unsigned CONF_PERIODO       = 1250,
    parameter int unsigned PERIODOS_POR_PASSO = 4000,
    parameter int unsigned N_VARREDURAS       = 1
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       iniciar_i,
    input  logic       parar_i,
    input  logic       manual_req_i,
    input  logic [1:0] manual_pos_i,
    output logic [1:0] largura_o,
    output logic       ocupado_o,
    output logic       passo_o,
    output logic       pronto_o,
    output logic [2:0] db_estado_o,
    output logic [1:0] db_posicao_o
);

    localparam logic [31:0] C_T_ULTIMO = 32'(CONF_PERIODO * PERIODOS_POR_PASSO - 1);
    localparam logic [31:0] C_N_VARR   = 32'(N_VARREDURAS);
    localparam logic        C_FINITO   = (N_VARREDURAS != 0);

    typedef enum logic [2:0] {
        REPOUSO   = 3'd0,
        POSICIONA = 3'd1,
        AVANCA    = 3'd2,
        MANUAL    = 3'd3,
        FIM       = 3'd4
    } estado_t;

    estado_t     estado_q;
    logic [1:0]  largura_q;
    logic [1:0]  posicao_q;
    logic        dir_q;        // 0 = rising, 1 = falling
    logic [31:0] cnt_q;
    logic [31:0] contagem_q;
    logic        ativo_q;
    logic        passo_q;
    logic        pronto_q;
    logic        ocupado_q;

    logic [1:0]  posicao_d;
    logic        dir_d;
    logic [31:0] contagem_d;
    logic        fim_d;

    // Next sweep position, applied when leaving AVANCA.
    always_comb begin
        posicao_d  = posicao_q;
        dir_d      = dir_q;
        contagem_d = contagem_q;
        fim_d      = 1'b0;
        if (!dir_q) begin
            if (posicao_q != 2'b11) begin
                posicao_d = posicao_q + 2'd1;
            end else begin
                dir_d     = 1'b1;
                posicao_d = 2'b10;
            end
        end else if (posicao_q != 2'b00) begin
            posicao_d = posicao_q - 2'd1;
        end else begin
            contagem_d = contagem_q + 32'd1;
            if (C_FINITO && (contagem_d == C_N_VARR)) begin
                fim_d = 1'b1;
            end else begin
                dir_d     = 1'b0;
                posicao_d = 2'b01;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            estado_q   <= REPOUSO;
            largura_q  <= 2'b00;
            posicao_q  <= 2'b00;
            dir_q      <= 1'b0;
            cnt_q      <= 32'd0;
            contagem_q <= 32'd0;
            ativo_q    <= 1'b0;
            passo_q    <= 1'b0;
            pronto_q   <= 1'b0;
            ocupado_q  <= 1'b0;
        end else begin
            passo_q  <= 1'b0;
            pronto_q <= 1'b0;
            case (estado_q)
                REPOUSO: begin
                    largura_q <= 2'b00;
                    if (manual_req_i) begin
                        estado_q  <= MANUAL;
                        largura_q <= manual_pos_i;
                        ocupado_q <= 1'b1;
                    end else if (iniciar_i) begin
                        estado_q   <= POSICIONA;
                        posicao_q  <= 2'b00;
                        dir_q      <= 1'b0;
                        contagem_q <= 32'd0;
                        cnt_q      <= 32'd0;
                        ativo_q    <= 1'b1;
                        ocupado_q  <= 1'b1;
                    end
                end
                POSICIONA: begin
                    if (parar_i) begin
                        estado_q  <= REPOUSO;
                        largura_q <= 2'b00;
                        ativo_q   <= 1'b0;
                        ocupado_q <= 1'b0;
                    end else if (manual_req_i) begin
                        estado_q  <= MANUAL;
                        largura_q <= manual_pos_i;
                    end else if (cnt_q == C_T_ULTIMO) begin
                        estado_q <= AVANCA;
                        cnt_q    <= 32'd0;
                        passo_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                AVANCA: begin
                    if (parar_i) begin
                        estado_q  <= REPOUSO;
                        largura_q <= 2'b00;
                        ativo_q   <= 1'b0;
                        ocupado_q <= 1'b0;
                    end else begin
                        posicao_q  <= posicao_d;
                        dir_q      <= dir_d;
                        contagem_q <= contagem_d;
                        if (fim_d) begin
                            estado_q  <= FIM;
                            pronto_q  <= 1'b1;
                            largura_q <= 2'b00;
                            ativo_q   <= 1'b0;
                        end else begin
                            estado_q  <= POSICIONA;
                            largura_q <= posicao_d;
                            cnt_q     <= 32'd0;
                        end
                    end
                end
                MANUAL: begin
                    if (manual_req_i) begin
                        largura_q <= manual_pos_i;
                        if (parar_i) begin
                            ativo_q <= 1'b0;
                        end
                    end else if (ativo_q && !parar_i) begin
                        // Resume with a full dwell at the saved position.
                        estado_q  <= POSICIONA;
                        largura_q <= posicao_q;
                        cnt_q     <= 32'd0;
                    end else begin
                        estado_q  <= REPOUSO;
                        largura_q <= 2'b00;
                        ativo_q   <= 1'b0;
                        ocupado_q <= 1'b0;
                    end
                end
                FIM: begin
                    estado_q  <= REPOUSO;
                    largura_q <= 2'b00;
                    ocupado_q <= 1'b0;
                end
                default: begin
                    estado_q  <= REPOUSO;
                    largura_q <= 2'b00;
                    ativo_q   <= 1'b0;
                    ocupado_q <= 1'b0;
                end
            endcase
        end
    end

    assign largura_o    = largura_q;
    assign ocupado_o    = ocupado_q;
    assign passo_o      = passo_q;
    assign pronto_o     = pronto_q;
    assign db_estado_o  = estado_q;
    assign db_posicao_o = posicao_q;

endmodule
`default_nettype wire
